// File: rtl/seg_scan_reader.sv
// Purpose: rebuild the hex value shown on a multiplexed active-low 7-segment bus, one frame per in-order scan.
// Latency: a digit is accepted SETTLE+1 edges after it appears on the pins; the frame is presented on the following edge.
// Backpressure: a frame is held until out_ready; a frame completing while one is still held is dropped and overrun latches.
module seg_scan_reader #(
    parameter int DIGITS = 4,
    parameter int SETTLE = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            seg_in,
    input  logic [DIGITS-1:0]     an_in,
    output logic [4*DIGITS-1:0]   value_out,
    output logic [DIGITS-1:0]     dp_out,
    output logic [DIGITS-1:0]     bad_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overrun
);

    localparam int VW = 4 * DIGITS;
    localparam int EW = $clog2(DIGITS + 1);
    localparam int SW = DIGITS + 8;
    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    // Registered pin samples and stability tracking.
    logic [7:0]        s_seg_q, s_seg_d;
    logic [DIGITS-1:0] s_an_q, s_an_d;
    logic [SW-1:0]     prev_q, prev_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              done_q, done_d;

    // Frame assembly and output registers.
    state_t            state_q, state_d;
    logic [EW-1:0]     expect_q, expect_d;
    logic [VW-1:0]     wval_q, wval_d;
    logic [DIGITS-1:0] wdp_q, wdp_d;
    logic [DIGITS-1:0] wbad_q, wbad_d;
    logic [VW-1:0]     val_q, val_d;
    logic [DIGITS-1:0] dpo_q, dpo_d;
    logic [DIGITS-1:0] bado_q, bado_d;
    logic              valid_q, valid_d;
    logic              ovr_q, ovr_d;

    // Combinational helpers.
    logic [SW-1:0]     cur_smp;
    logic              same_smp;
    logic              one_zero;
    logic [EW-1:0]     dig_idx;
    int                dig_i;
    logic              accept;
    logic [3:0]        nib;
    logic              nib_bad;
    logic              dp_bit;
    logic              is_last;
    logic [VW-1:0]     mrg_val, st_val, frm_val;
    logic [DIGITS-1:0] mrg_dp, st_dp, frm_dp;
    logic [DIGITS-1:0] mrg_bad, st_bad, frm_bad;
    logic              complete;

    // Input stage and stability counter: count repeats of the registered sample, accept once per stable value.
    always_comb begin
        s_seg_d  = seg_in;
        s_an_d   = an_in;
        cur_smp  = {s_an_q, s_seg_q};
        same_smp = (cur_smp == prev_q);
        prev_d   = cur_smp;
        if (same_smp) begin
            cnt_d  = (cnt_q == SETTLE_C) ? cnt_q : (cnt_q + 4'd1);
            done_d = done_q | (cnt_q == SETTLE_C);
        end else begin
            cnt_d  = 4'd1;
            done_d = 1'b0;
        end
    end

    // Locate the single enabled digit; zero or several enables disqualify the sample.
    always_comb begin
        int zcnt;
        zcnt    = 0;
        dig_idx = '0;
        dig_i   = 0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!s_an_q[i]) begin
                dig_idx = EW'(i);
                dig_i   = i;
                zcnt    = zcnt + 1;
            end
        end
        one_zero = (zcnt == 1);
        accept   = (cnt_q == SETTLE_C) && !done_q && one_zero;
        is_last  = (dig_idx == EW'(DIGITS - 1));
    end

    // Segment pattern back to nibble; dp does not take part in the lookup.
    always_comb begin
        nib     = 4'h0;
        nib_bad = 1'b0;
        dp_bit  = ~s_seg_q[7];
        case (s_seg_q[6:0])
            7'h40: nib = 4'h0;
            7'h79: nib = 4'h1;
            7'h24: nib = 4'h2;
            7'h30: nib = 4'h3;
            7'h19: nib = 4'h4;
            7'h12: nib = 4'h5;
            7'h02: nib = 4'h6;
            7'h78: nib = 4'h7;
            7'h00: nib = 4'h8;
            7'h10: nib = 4'h9;
            7'h08: nib = 4'hA;
            7'h03: nib = 4'hB;
            7'h46: nib = 4'hC;
            7'h21: nib = 4'hD;
            7'h06: nib = 4'hE;
            7'h0E: nib = 4'hF;
            default: begin
                nib     = 4'h0;
                nib_bad = 1'b1;
            end
        endcase
    end

    // Candidate working images: current digit merged into the partial frame, or a fresh frame from digit 0.
    always_comb begin
        mrg_val = wval_q;
        mrg_dp  = wdp_q;
        mrg_bad = wbad_q;
        mrg_val[4*dig_i +: 4] = nib;
        mrg_dp[dig_i]         = dp_bit;
        mrg_bad[dig_i]        = nib_bad;
        st_val      = '0;
        st_dp       = '0;
        st_bad      = '0;
        st_val[3:0] = nib;
        st_dp[0]    = dp_bit;
        st_bad[0]   = nib_bad;
    end

    // Scan-order FSM plus output handshake; out_valid is tracked apart from the state so a new scan can run while a frame is held.
    always_comb begin
        state_d  = state_q;
        expect_d = expect_q;
        wval_d   = wval_q;
        wdp_d    = wdp_q;
        wbad_d   = wbad_q;
        val_d    = val_q;
        dpo_d    = dpo_q;
        bado_d   = bado_q;
        valid_d  = valid_q;
        ovr_d    = ovr_q;
        frm_val  = mrg_val;
        frm_dp   = mrg_dp;
        frm_bad  = mrg_bad;
        complete = 1'b0;

        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            COLLECT: begin
                if (accept) begin
                    if (dig_idx == expect_q) begin
                        wval_d   = mrg_val;
                        wdp_d    = mrg_dp;
                        wbad_d   = mrg_bad;
                        expect_d = expect_q + EW'(1);
                        complete = is_last;
                    end else if (dig_idx == '0) begin
                        wval_d   = st_val;
                        wdp_d    = st_dp;
                        wbad_d   = st_bad;
                        expect_d = EW'(1);
                    end else begin
                        state_d  = IDLE;
                        expect_d = '0;
                    end
                end
            end
            default: begin
                if (accept && (dig_idx == '0)) begin
                    wval_d   = st_val;
                    wdp_d    = st_dp;
                    wbad_d   = st_bad;
                    expect_d = EW'(1);
                    state_d  = COLLECT;
                    frm_val  = st_val;
                    frm_dp   = st_dp;
                    frm_bad  = st_bad;
                    complete = (DIGITS == 1);
                end else if ((state_q == HOLD) && valid_q && out_ready) begin
                    state_d = IDLE;
                end
            end
        endcase

        if (complete) begin
            expect_d = '0;
            if (!valid_q || out_ready) begin
                val_d   = frm_val;
                dpo_d   = frm_dp;
                bado_d  = frm_bad;
                valid_d = 1'b1;
                state_d = HOLD;
            end else begin
                ovr_d   = 1'b1;
                state_d = IDLE;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_seg_q  <= 8'hFF;
            s_an_q   <= '1;
            prev_q   <= '1;
            cnt_q    <= 4'd0;
            done_q   <= 1'b0;
            state_q  <= IDLE;
            expect_q <= '0;
            wval_q   <= '0;
            wdp_q    <= '0;
            wbad_q   <= '0;
            val_q    <= '0;
            dpo_q    <= '0;
            bado_q   <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            s_seg_q  <= s_seg_d;
            s_an_q   <= s_an_d;
            prev_q   <= prev_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            state_q  <= state_d;
            expect_q <= expect_d;
            wval_q   <= wval_d;
            wdp_q    <= wdp_d;
            wbad_q   <= wbad_d;
            val_q    <= val_d;
            dpo_q    <= dpo_d;
            bado_q   <= bado_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
        end
    end

    assign value_out = val_q;
    assign dp_out    = dpo_q;
    assign bad_out   = bado_q;
    assign out_valid = valid_q;
    assign overrun   = ovr_q;

endmodule

// File: doc/seg_scan_reader.md
# seg_scan_reader

Receive-side counterpart of the calculator's hex-to-segment display path: it monitors a multiplexed, active-low seven-segment bus (segment lines plus per-digit enables) and rebuilds the displayed hex value. Each digit is filtered for stability, decoded from its segment pattern back to a nibble, and assembled in scan order. Whole frames are handed to a consumer over a valid/ready handshake. It serves as the loopback checker and readback path for the display subsystem.

## Interface
- DIGITS, 4, number of multiplexed digits (1-8)
- SETTLE, 3, consecutive identical samples required to accept a digit (2-15)
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- seg_in  in  8  active-low segments {dp,g,f,e,d,c,b,a}, bit 0 = a
- an_in  in  DIGITS  active-low digit enables, bit i = digit i (digit 0 = least-significant nibble)
- value_out  out  4*DIGITS  decoded frame, digit i at [4i+3:4i]
- dp_out  out  DIGITS  decimal point lit (seg_in[7]==0) per digit
- bad_out  out  DIGITS  per-digit flag: pattern not in the hex table
- out_valid  out  1  frame available
- out_ready  in  1  consumer accepts frame
- overrun  out  1  sticky: a completed frame was dropped

## Operation
- Input stage: seg_in and an_in are registered once (s_seg, s_an); all logic uses the registered copies.
- Stability counter: increments while {s_an,s_seg} equals the previous cycle's value; it resets to 1 on any change. It saturates at SETTLE. A digit is accepted on the single cycle the counter reaches SETTLE, and only if s_an has exactly one zero bit. All-ones, or more than one zero, is never accepted.
- Decode table (active-low seg[6:0]; dp is ignored for decode): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex).
- Any other pattern decodes to nibble 0 and sets that digit's bad bit.
- FSM states: IDLE, COLLECT, HOLD.
  - IDLE: waits for acceptance of digit 0, then stores it, sets expect=1, and goes to COLLECT. With DIGITS==1 the frame completes immediately.
  - COLLECT, accepted digit == expect: store it, expect+1. If it was digit DIGITS-1, the frame is complete.
  - COLLECT, accepted digit 0: discard the partial frame, store digit 0, expect=1.
  - COLLECT, any other accepted digit: discard the partial frame and go to IDLE.
- Frame complete: if out_valid==0, or out_valid==1 with out_ready==1 in the same cycle, copy the working registers to value_out/dp_out/bad_out. Set out_valid=1 and go to HOLD. Otherwise drop the frame, set overrun, and go to IDLE.
- HOLD: out_valid stays high and outputs stay stable until out_ready. On the handshake, out_valid clears next cycle and the FSM goes to IDLE. Scanning continues during HOLD: digit-0 acceptance starts a new frame in COLLECT without waiting, while out_valid remains asserted.
- overrun clears only on reset.

## Timing
- Reset values: value_out=0, dp_out=0, bad_out=0, out_valid=0, overrun=0, FSM=IDLE, expect=0, stability counter=0, s_an=all ones, s_seg=FF.
- Reset asserted mid-frame discards the partial frame. Any presented frame is withdrawn next cycle.
- Acceptance latency: a digit is accepted SETTLE cycles after its value first appears on the pins. This is 1 register cycle plus SETTLE-1 repeats, so acceptance occurs on the (SETTLE+1)th rising edge after the change.
- Frame output: value_out/out_valid update on the edge after the last digit's acceptance cycle.
- A digit held indefinitely is accepted exactly once. Re-acceptance requires a change of {an,seg}.
- Handshake: a transfer happens on a clock edge where out_valid && out_ready. out_ready is ignored while out_valid==0.

## Test plan
- Clean scan of "1A3F" (digit0=F: an=E seg=8E; digit1=3: an=D seg=B0; digit2=A: an=B seg=88; digit3=1: an=7 seg=F9), each digit held 8 cycles, SETTLE=3, out_ready=1 -> value_out=16'h1A3F, bad_out=0, dp_out=0, out_valid one cycle per frame.
- Glitch: digit1 seg toggles every cycle for 10 cycles, then stable B0 -> no acceptance during toggling; frame completes with digit1=3.
- Illegal pattern FF (blank) on digit2 -> nibble 0, bad_out=4'b0100, frame still delivered.
- Out-of-order scan 0,2,1,... -> digit2 aborts to IDLE; no frame until the next in-order 0,1,2,3 pass.
- out_ready held 0 across two full scans -> first frame held stable, second dropped, overrun=1. out_ready=1 then gives one transfer and out_valid=0 next cycle.
- Reset asserted with digits 0-1 collected -> all outputs return to reset values next cycle; a subsequent full scan yields a correct frame.
